wb_stage_ex: RTL
================

# wb_stage_ex

Parametrised write-back stage that succeeds the fixed 32-bit WB register: it holds one instruction from MEM, commits its register-file write, and stalls while the shared RF write port is busy. It retires exceptions and ERTN by raising a one-cycle flush toward the front stages and exporting the exception record to the CSR block. It also maintains a retired-instruction counter. It sits between the MEM stage and the register file, CSR unit and trace-debug port.

## Interface
- DATA_W, 32, RF data width; must be a multiple of 8
- RADDR_W, 5, RF address width
- PC_W, 32, PC width
- ECODE_W, 6, exception code width
- CNT_W, 64, retire counter width
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- ms2ws_valid  in  1  MEM holds a valid instruction for WB
- ws_allowin  out  1  WB accepts this cycle
- ms_pc  in  PC_W  instruction PC
- ms_rf_zip  in  1+RADDR_W+DATA_W  {we, waddr, wdata}
- ms_ex  in  1  instruction carries an exception
- ms_ecode  in  ECODE_W  exception code, meaningful when ms_ex=1
- ms_ertn  in  1  instruction is ERTN
- rf_wr_ready  in  1  shared RF write port free this cycle
- ws_rf_zip  out  1+RADDR_W+DATA_W  {effective we, waddr, wdata} for ID forwarding/RF
- wb_flush  out  1  one-cycle flush pulse to IF/ID/EX/MEM
- ex_valid, ex_pc, ex_ecode  out  1/PC_W/ECODE_W  exception commit record to CSR
- ertn_valid  out  1  ERTN commit to CSR
- retire_cnt  out  CNT_W  retired-instruction count
- debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata  out  PC_W/DATA_W/8/RADDR_W/DATA_W  trace port

## Operation
- Internal registers: ws_valid, pc, we, waddr, wdata, ex, ecode, ertn.
- All registers clear to 0 asynchronously when resetn=0.
- Effective write: eff_we = ws_valid & we & ~ex.
- Ready-go and acceptance:
  - ws_ready_go = ~eff_we | rf_wr_ready.
  - ws_allowin = ~ws_valid | ws_ready_go.
  - commit = ws_valid & ws_ready_go.
- Payload loads when ms2ws_valid & ws_allowin. It holds unchanged while stalled.
- ws_valid update:
  - If wb_flush: ws_valid <= 0. An instruction offered in the same cycle is younger and is dropped.
  - Else, if ws_allowin: ws_valid <= ms2ws_valid.
- wb_flush = commit & (ex | ertn).
- ex_valid = commit & ex. ex_pc = pc. ex_ecode = ecode.
- ertn_valid = commit & ertn & ~ex. Exception has priority over ERTN.
- ws_rf_zip = {eff_we, waddr, wdata}.
  - Asserted while stalled, so ID forwarding still sees the pending write.
  - The RF samples it only when rf_wr_ready=1.
- Trace port:
  - debug_wb_rf_we = {DATA_W/8{commit & eff_we}}.
  - debug_wb_pc, debug_wb_rf_wnum and debug_wb_rf_wdata track the registers.
- retire_cnt increments by 1 on commit & ~ex. Exceptions do not retire; ERTN does. It wraps modulo 2^CNT_W.

## Timing
- Latency: an instruction accepted at edge N is visible on all outputs after edge N and commits in cycle N+1 when rf_wr_ready=1.
- Stall: each cycle with eff_we & ~rf_wr_ready holds the instruction, deasserts ws_allowin and suppresses debug we. Commit occurs in the first cycle rf_wr_ready=1.
- Throughput: 1 instruction/cycle when rf_wr_ready=1.
- Stall is never needed when eff_we=0; rf_wr_ready is ignored in that case.
- wb_flush, ex_valid and ertn_valid are combinational from registers, 1 cycle wide per excepting instruction, and never repeat.
- Reset mid-stall: the pending instruction is discarded with no commit. retire_cnt = 0 on the first cycle after release.
- Reset values of all outputs are 0. The exception is ws_allowin, which is 1.

## Structure
- Shared package wb_pkg holds:
  - default widths;
  - ECODE constants (SYS, BRK, INE, ADE, ALE);
  - zip-field offset localparams shared with MEM/ID.
- Sub-module wb_retire_counter: parametrised CNT_W counter with inc enable and async reset. It is reused for the CSR cycle counter.

## Test plan
- Reset, then a back-to-back stream pc=0x1C000000..+0x10 with we=1, rf_wr_ready=1 -> 5 debug writes on consecutive cycles, retire_cnt=5.
- rf_wr_ready=0 for 3 cycles on a we=1 instruction -> ws_allowin=0 for those 3 cycles, ws_rf_zip held, single debug write on the 4th cycle.
- ms_ex=1, ecode=0x0B, we=1 at pc=0x1C000040 -> one-cycle wb_flush/ex_valid, ex_pc=0x1C000040, no RF write, retire_cnt unchanged, younger instruction offered that cycle dropped.
- ERTN with we=0 while rf_wr_ready=0 -> commits immediately, ertn_valid=1 for one cycle, retire_cnt+1.
- Preload retire_cnt to 2^CNT_W-1 via force and commit one instruction -> retire_cnt=0.
- resetn asserted mid-stall -> all outputs 0 immediately, ws_allowin=1, no commit after release.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, exception codes and rf zip layout for the WB stage
package wb_pkg;

    localparam int WB_DATA_W  = 32;
    localparam int WB_RADDR_W = 5;
    localparam int WB_PC_W    = 32;
    localparam int WB_ECODE_W = 6;
    localparam int WB_CNT_W   = 64;

    // Exception codes carried in the exception record toward the CSR unit
    localparam logic [WB_ECODE_W-1:0] ECODE_ADE = 6'h08;
    localparam logic [WB_ECODE_W-1:0] ECODE_ALE = 6'h09;
    localparam logic [WB_ECODE_W-1:0] ECODE_SYS = 6'h0B;
    localparam logic [WB_ECODE_W-1:0] ECODE_BRK = 6'h0C;
    localparam logic [WB_ECODE_W-1:0] ECODE_INE = 6'h0D;

    // rf zip layout {we, waddr, wdata}, shared with the MEM and ID stages
    localparam int ZIP_WDATA_LSB = 0;
    localparam int ZIP_WADDR_LSB = WB_DATA_W;
    localparam int ZIP_WE_BIT    = WB_DATA_W + WB_RADDR_W;
    localparam int ZIP_W         = 1 + WB_RADDR_W + WB_DATA_W;

endpackage

// File: rtl/wb_retire_counter.sv
// rtl/wb_retire_counter.sv - free-running wrap-around event counter with increment enable
module wb_retire_counter
    import wb_pkg::*;
#(
    parameter int CNT_W = WB_CNT_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;

    // Count one per enabled cycle; wraps naturally at 2^CNT_W
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/wb_stage_ex.sv
// rtl/wb_stage_ex.sv - write-back stage with rf port stall, exception/ERTN flush and retire count
module wb_stage_ex
    import wb_pkg::*;
#(
    parameter int DATA_W  = WB_DATA_W,
    parameter int RADDR_W = WB_RADDR_W,
    parameter int PC_W    = WB_PC_W,
    parameter int ECODE_W = WB_ECODE_W,
    parameter int CNT_W   = WB_CNT_W
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        ms2ws_valid,
    output logic                        ws_allowin,
    input  logic [PC_W-1:0]             ms_pc,
    input  logic [RADDR_W+DATA_W:0]     ms_rf_zip,
    input  logic                        ms_ex,
    input  logic [ECODE_W-1:0]          ms_ecode,
    input  logic                        ms_ertn,
    input  logic                        rf_wr_ready,
    output logic [RADDR_W+DATA_W:0]     ws_rf_zip,
    output logic                        wb_flush,
    output logic                        ex_valid,
    output logic [PC_W-1:0]             ex_pc,
    output logic [ECODE_W-1:0]          ex_ecode,
    output logic                        ertn_valid,
    output logic [CNT_W-1:0]            retire_cnt,
    output logic [PC_W-1:0]             debug_wb_pc,
    output logic [DATA_W/8-1:0]         debug_wb_rf_we,
    output logic [RADDR_W-1:0]          debug_wb_rf_wnum,
    output logic [DATA_W-1:0]           debug_wb_rf_wdata
);

    localparam int WE_BIT    = RADDR_W + DATA_W;
    localparam int WADDR_LSB = DATA_W;

    logic                ws_valid;
    logic [PC_W-1:0]     pc_q;
    logic                we_q;
    logic [RADDR_W-1:0]  waddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                ex_q;
    logic [ECODE_W-1:0]  ecode_q;
    logic                ertn_q;

    logic eff_we;
    logic ws_ready_go;
    logic commit;
    logic load;

    // Excepting instructions never write the RF, so they never wait for the port
    assign eff_we      = ws_valid & we_q & ~ex_q;
    assign ws_ready_go = ~eff_we | rf_wr_ready;
    assign ws_allowin  = ~ws_valid | ws_ready_go;
    assign commit      = ws_valid & ws_ready_go;
    assign load        = ms2ws_valid & ws_allowin;

    // Occupancy: a flush kills whatever MEM offers this cycle, since it is younger
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_valid <= 1'b0;
        end else if (wb_flush) begin
            ws_valid <= 1'b0;
        end else if (ws_allowin) begin
            ws_valid <= ms2ws_valid;
        end
    end

    // Payload capture; held stable for the whole stall so forwarding stays coherent
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q    <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            ex_q    <= 1'b0;
            ecode_q <= '0;
            ertn_q  <= 1'b0;
        end else if (load) begin
            pc_q    <= ms_pc;
            we_q    <= ms_rf_zip[WE_BIT];
            waddr_q <= ms_rf_zip[WADDR_LSB +: RADDR_W];
            wdata_q <= ms_rf_zip[DATA_W-1:0];
            ex_q    <= ms_ex;
            ecode_q <= ms_ecode;
            ertn_q  <= ms_ertn;
        end
    end

    // Exception outranks ERTN; both redirect the front end through the same flush
    assign wb_flush   = commit & (ex_q | ertn_q);
    assign ex_valid   = commit & ex_q;
    assign ex_pc      = pc_q;
    assign ex_ecode   = ecode_q;
    assign ertn_valid = commit & ertn_q & ~ex_q;

    assign ws_rf_zip  = {eff_we, waddr_q, wdata_q};

    assign debug_wb_pc       = pc_q;
    assign debug_wb_rf_we    = {(DATA_W/8){commit & eff_we}};
    assign debug_wb_rf_wnum  = waddr_q;
    assign debug_wb_rf_wdata = wdata_q;

    wb_retire_counter #(
        .CNT_W (CNT_W)
    ) u_retire (
        .clk    (clk),
        .resetn (resetn),
        .inc    (commit & ~ex_q),
        .cnt    (retire_cnt)
    );

endmodule
